// File: rtl/glitch_filter_pkg.sv
// Shared definitions for the multi-channel glitch filter.
// Contents:
//   gf_mode_e  debounce mode selector (consecutive-run or integrator)
package glitch_filter_pkg;

    typedef enum logic {
        MODE_CONSEC = 1'b0,
        MODE_INTEG  = 1'b1
    } gf_mode_e;

endpackage : glitch_filter_pkg

// File: rtl/glitch_filter_mc_ticker.sv
// gf_ticker: divided sampling-tick generator shared by all filter channels.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   en       1 = count and emit ticks; 0 = counter parked at zero, no ticks
//   clk_div  tick period minus one, in clk cycles
//   tick     combinational strobe, high in the cycle where the count matches clk_div
module gf_ticker #(
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DIVW-1:0] clk_div,
    output logic            tick
);

    logic [DIVW-1:0] cnt;

    // An exact match is used rather than >= so that lowering clk_div below
    // the current count lets the counter wrap through 2^DIVW before resuming.
    always_comb begin
        tick = en && (cnt == clk_div);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : gf_ticker

// File: rtl/glitch_filter_mc.sv
// glitch_filter_mc: NCH-channel debouncer with runtime-selectable mode.
// Each raw input passes through a 2-flop synchroniser, is sampled on a shared
// divided tick and filtered either as a consecutive-run counter or as a
// saturating integrator with hysteresis.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   en       1 = sampling enabled; 0 = ticker stopped, filter state frozen
//   clk_div  tick period = clk_div+1 clk cycles
//   mode     0 = consecutive-run, 1 = integrator
//   thresh   threshold T (0 is treated as 1)
//   in       raw asynchronous inputs
//   out      filtered levels
//   rise     one-cycle pulse when out[i] goes 0->1
//   fall     one-cycle pulse when out[i] goes 1->0
import glitch_filter_pkg::*;

module glitch_filter_mc #(
    parameter int           NCH     = 4,
    parameter int           CW      = 4,
    parameter int           DIVW    = 8,
    parameter logic [NCH-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DIVW-1:0] clk_div,
    input  logic            mode,
    input  logic [CW-1:0]   thresh,
    input  logic [NCH-1:0]  in,
    output logic [NCH-1:0]  out,
    output logic [NCH-1:0]  rise,
    output logic [NCH-1:0]  fall
);

    logic [NCH-1:0] sync1;
    logic [NCH-1:0] in_s;
    logic [NCH-1:0] out_n;
    gf_mode_e       mode_q;
    logic           mode_chg;
    logic           tick;
    logic [CW-1:0]  t_eff;

    gf_ticker #(
        .DIVW (DIVW)
    ) u_ticker (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clk_div (clk_div),
        .tick    (tick)
    );

    // The synchroniser runs regardless of en so in_s is already settled
    // when sampling is re-enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RST_VAL;
            in_s  <= RST_VAL;
        end else begin
            sync1 <= in;
            in_s  <= sync1;
        end
    end

    // A mode change invalidates the shared run/acc register, so it is
    // detected against a registered copy and used to clear all channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_CONSEC;
        end else begin
            mode_q <= gf_mode_e'(mode);
        end
    end

    always_comb begin
        mode_chg = (gf_mode_e'(mode) != mode_q);
        t_eff    = (thresh == '0) ? CW'(1) : thresh;
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_n;
        logic [CW-1:0] acc_step;
        logic          out_nxt;

        // cnt_q holds the run length in consecutive mode and the integrator
        // level in integrator mode. The final clamp to T handles a threshold
        // lowered below the current accumulator level.
        always_comb begin
            cnt_n    = cnt_q;
            out_nxt  = out[ch];
            acc_step = '0;
            if (mode_chg) begin
                cnt_n = '0;
            end else if (tick) begin
                if (mode_q == MODE_CONSEC) begin
                    if (in_s[ch] == out[ch]) begin
                        cnt_n = '0;
                    end else if (cnt_q == t_eff - CW'(1)) begin
                        out_nxt = in_s[ch];
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end else begin
                    if (in_s[ch]) begin
                        acc_step = (cnt_q >= t_eff) ? t_eff : cnt_q + CW'(1);
                    end else begin
                        acc_step = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
                    end
                    cnt_n = (acc_step > t_eff) ? t_eff : acc_step;
                    if (cnt_n == t_eff) begin
                        out_nxt = 1'b1;
                    end else if (cnt_n == '0) begin
                        out_nxt = 1'b0;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_n;
            end
        end

        assign out_n[ch] = out_nxt;
    end

    // Edge pulses are registered alongside out so they line up with the
    // first cycle the new level is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= RST_VAL;
            rise <= '0;
            fall <= '0;
        end else begin
            out  <= out_n;
            rise <= out_n & ~out;
            fall <= ~out_n & out;
        end
    end

endmodule : glitch_filter_mc

// File: tb/tb_glitch_filter_mc.sv
// Directed self-checking bench for glitch_filter_mc (NCH=4, CW=4, DIVW=8).
module tb_glitch_filter_mc;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] clk_div;
    logic       mode;
    logic [3:0] thresh;
    logic [3:0] raw;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;

    int checks;
    int failures;

    glitch_filter_mc #(
        .NCH     (4),
        .CW      (4),
        .DIVW    (8),
        .RST_VAL (4'b0000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clk_div (clk_div),
        .mode    (mode),
        .thresh  (thresh),
        .in      (raw),
        .out     (out),
        .rise    (rise),
        .fall    (fall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; clk_div = 8'd0; mode = 1'b0; thresh = 4'd3;
        raw = 4'b0101;
        step();
        raw = 4'b1010;
        step();
        checks++;
        if (out !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_state: out=%b rise=%b fall=%b expected 0000/0000/0000", out, rise, fall);
        end
        rst = 1'b0; raw = 4'b0000;
        step();
        checks++;
        if (out !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_release: out=%b rise=%b fall=%b expected 0000/0000/0000", out, rise, fall);
        end
        step(); step();
    endtask

    task automatic test_consec();
        raw = 4'b0001;
        step();                    // edge 0
        step(); step(); step();    // edges 1..3
        checks++;
        if (out !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL consec_early: out=%b expected 0000", out);
        end
        step();                    // edge 4
        checks++;
        if (out !== 4'b0001 || rise !== 4'b0001 || fall !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL consec_rise: out=%b rise=%b fall=%b expected 0001/0001/0000", out, rise, fall);
        end
        step();
        checks++;
        if (out !== 4'b0001 || rise !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL consec_pulse_width: out=%b rise=%b expected 0001/0000", out, rise);
        end
        // Two-cycle glitch on channel 1 must be rejected.
        raw = 4'b0011;
        step(); step();
        raw = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (out !== 4'b0001 || rise !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL consec_glitch[%0d]: out=%b rise=%b expected 0001/0000", i, out, rise);
            end
        end
        raw = 4'b0000;
        step(); step(); step(); step();
        checks++;
        if (out !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL consec_fall_early: out=%b expected 0001", out);
        end
        step();
        checks++;
        if (out !== 4'b0000 || fall !== 4'b0001 || rise !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL consec_fall: out=%b fall=%b rise=%b expected 0000/0001/0000", out, fall, rise);
        end
    endtask

    task automatic test_integ();
        logic [11:0] pat;
        logic [9:0]  exp_lvl;
        logic [3:0]  exp_o;
        logic [3:0]  exp_r;
        logic [3:0]  exp_f;
        int          k;
        pat     = 12'b000000111011;
        exp_lvl = 10'b0111100000;
        mode = 1'b1; thresh = 4'd4; raw = 4'b0000;
        step(); step(); step();
        for (int i = 0; i < 12; i++) begin
            raw    = 4'b0000;
            raw[2] = pat[i];
            step();
            k = i - 2;
            if (k >= 0) begin
                exp_o = 4'b0000; exp_o[2] = exp_lvl[k];
                exp_r = 4'b0000; exp_r[2] = (k == 5);
                exp_f = 4'b0000; exp_f[2] = (k == 9);
                checks++;
                if (out !== exp_o || rise !== exp_r || fall !== exp_f) begin
                    failures++;
                    $display("[TB] FAIL integ_tick%0d: out=%b rise=%b fall=%b expected %b/%b/%b",
                             k + 1, out, rise, fall, exp_o, exp_r, exp_f);
                end
            end
        end
    endtask

    task automatic test_ticker();
        en = 1'b0; clk_div = 8'd3; thresh = 4'd2; raw = 4'b1000;
        step(); step(); step(); step();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();                // E .. E+3, first tick at E+3 -> acc 1
            checks++;
            if (out !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL ticker_run[%0d]: out=%b expected 0000", i, out);
            end
        end
        step();                    // E+4, ticker count now 1
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (out !== 4'b0000 || rise !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL ticker_frozen[%0d]: out=%b rise=%b expected 0000/0000", i, out, rise);
            end
        end
        en = 1'b1;
        step(); step(); step();    // R .. R+2
        checks++;
        if (out !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL ticker_resume_early: out=%b expected 0000", out);
        end
        step();                    // R+3: acc 1 -> 2 == T
        checks++;
        if (out !== 4'b1000 || rise !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL ticker_resume: out=%b rise=%b expected 1000/1000", out, rise);
        end
    endtask

    task automatic test_mode_switch();
        mode = 1'b0; thresh = 4'd3; clk_div = 8'd0; raw = 4'b0000;
        step();                    // M: mode change, counters cleared
        step(); step(); step();    // M+1..M+3: run on ch3 reaches 2
        mode = 1'b1;
        step();                    // M+4: mode change, no update
        checks++;
        if (out !== 4'b1000 || fall !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL mode_switch_hold: out=%b fall=%b expected 1000/0000", out, fall);
        end
        step();                    // M+5: integrator with acc 0 drops ch3
        checks++;
        if (out !== 4'b0000 || fall !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL mode_switch_integ: out=%b fall=%b expected 0000/1000", out, fall);
        end
        // Threshold 0 acts as T=1: out follows in_s every tick.
        mode = 1'b0; thresh = 4'd0;
        step(); step();
        raw = 4'b0101;
        step(); step();
        checks++;
        if (out !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL thresh0_early: out=%b expected 0000", out);
        end
        step();
        checks++;
        if (out !== 4'b0101 || rise !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL thresh0_rise: out=%b rise=%b expected 0101/0101", out, rise);
        end
        raw = 4'b0010;
        step(); step(); step();
        checks++;
        if (out !== 4'b0010 || rise !== 4'b0010 || fall !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL thresh0_follow: out=%b rise=%b fall=%b expected 0010/0010/0101", out, rise, fall);
        end
    endtask

    task automatic test_clamp();
        raw = 4'b0000;
        step(); step(); step(); step();
        mode = 1'b1; thresh = 4'd8; raw = 4'b0001;
        step();                    // C: mode change
        for (int i = 0; i < 6; i++) step();   // C+1..C+6
        raw = 4'b0000;
        step(); step();            // C+7, C+8: acc 7
        checks++;
        if (out !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL clamp_before: out=%b expected 0000", out);
        end
        thresh = 4'd3;
        step();                    // C+9: acc 6 clamped to 3 == T
        checks++;
        if (out !== 4'b0001 || rise !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL clamp_set: out=%b rise=%b expected 0001/0001", out, rise);
        end
        step(); step();            // acc 2, 1: hysteresis holds
        checks++;
        if (out !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL clamp_hold: out=%b expected 0001", out);
        end
        step();                    // acc 0
        checks++;
        if (out !== 4'b0000 || fall !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL clamp_release: out=%b fall=%b expected 0000/0001", out, fall);
        end
    endtask

    task automatic test_reset_mid();
        mode = 1'b0; thresh = 4'd0; raw = 4'b1111;
        step(); step(); step(); step();
        checks++;
        if (out !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL mid_setup: out=%b expected 1111", out);
        end
        rst = 1'b1;
        step();
        checks++;
        if (out !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL mid_reset: out=%b rise=%b fall=%b expected 0000/0000/0000", out, rise, fall);
        end
        rst = 1'b0;
        step();
        checks++;
        if (out !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL mid_release: out=%b rise=%b fall=%b expected 0000/0000/0000", out, rise, fall);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; en = 1'b0; clk_div = 8'd0; mode = 1'b0; thresh = 4'd0; raw = 4'b0000;
        test_reset();
        test_consec();
        test_integ();
        test_ticker();
        test_mode_switch();
        test_clamp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_glitch_filter_mc
